// File: rtl/pipelined_addsub_nbit.sv
// rtl/pipelined_addsub_nbit.sv - pipelined N-bit adder/subtractor with valid/ready handshake

// One CHUNK-bit ripple slice: the extra top bit is the slice carry-out.
module addsub_slice #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] sum,
  output logic             co
);

  // Add the slice operands and incoming carry at CHUNK+1 bits so nothing is lost.
  always_comb begin
    {co, sum} = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
  end

endmodule

// Carry chain cut into STAGES slices, one register per slice. Each stage
// register carries the full (possibly inverted) operands plus the partial
// result, so slice k only needs the carry registered by stage k-1. The last
// stage register is the output register; flags are computed one step early
// so no logic sits between the registers and the output pins.
module pipelined_addsub_nbit #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;

  // Stage registers: valid, effective operands, partial sum, slice carry.
  logic             v_q [STAGES];
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             c_q [STAGES];
  logic             ovf_q;
  logic             zero_q;

  // What each stage sees on its input side this cycle.
  logic             src_v [STAGES];
  logic [WIDTH-1:0] src_a [STAGES];
  logic [WIDTH-1:0] src_b [STAGES];
  logic [WIDTH-1:0] src_s [STAGES];
  logic             src_c [STAGES];

  // Slice adder results and the partial sum with slice k filled in.
  logic [CHUNK-1:0] slice_sum [STAGES];
  logic             slice_co  [STAGES];
  logic [WIDTH-1:0] nxt_s     [STAGES];

  logic             advance;
  logic             ovf_d;
  logic             zero_d;

  // Single global enable: the whole pipe moves unless a result is stuck at the output.
  always_comb begin
    advance  = !v_q[LAST] || out_ready;
    in_ready = advance;
  end

  // Stage 0 takes the ports (b inverted and borrow turned into carry for
  // subtract); every later stage takes the register of the stage before it.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      src_v[k] = 1'b0;
      src_a[k] = '0;
      src_b[k] = '0;
      src_s[k] = '0;
      src_c[k] = 1'b0;
    end
    src_v[0] = in_valid;
    src_a[0] = a;
    src_b[0] = op ? ~b : b;
    src_s[0] = '0;
    src_c[0] = cin ^ op;
    for (int k = 1; k < STAGES; k++) begin
      src_v[k] = v_q[k-1];
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
      src_s[k] = s_q[k-1];
      src_c[k] = c_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    addsub_slice #(.CHUNK(CHUNK)) u_slice (
      .x   (src_a[k][k*CHUNK +: CHUNK]),
      .y   (src_b[k][k*CHUNK +: CHUNK]),
      .ci  (src_c[k]),
      .sum (slice_sum[k]),
      .co  (slice_co[k])
    );
  end

  // Merge each stage's freshly computed slice into the partial result it carries.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      nxt_s[k] = src_s[k];
      nxt_s[k][k*CHUNK +: CHUNK] = slice_sum[k];
    end
  end

  // Flags from the completed sum entering the output register; overflow uses the
  // effective operands, so subtract is judged on a + ~b.
  always_comb begin
    ovf_d  = (src_a[LAST][WIDTH-1] == src_b[LAST][WIDTH-1]) &&
             (nxt_s[LAST][WIDTH-1] != src_a[LAST][WIDTH-1]);
    zero_d = (nxt_s[LAST] == '0);
  end

  // Pipeline registers: cleared asynchronously, otherwise advance together or hold together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= src_v[k];
        a_q[k] <= src_a[k];
        b_q[k] <= src_b[k];
        s_q[k] <= nxt_s[k];
        c_q[k] <= slice_co[k];
      end
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  // Outputs come straight from the last stage register.
  always_comb begin
    out_valid = v_q[LAST];
    s         = s_q[LAST];
    cout      = c_q[LAST];
    ovf       = ovf_q;
    zero      = zero_q;
  end

endmodule

// File: tb/tb_pipelined_addsub_nbit.sv
// tb/tb_pipelined_addsub_nbit.sv - randomized and directed bench for pipelined_addsub_nbit

module tb_pipelined_addsub_nbit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int wd [3] = '{8, 32, 8};
  int st [3] = '{2, 4, 1};

  logic [2:0]  in_valid_v  = '0;
  logic [2:0]  out_ready_v = '0;
  logic [2:0]  cin_v       = '0;
  logic [2:0]  op_v        = '0;
  logic [31:0] a_v [3]     = '{default: '0};
  logic [31:0] b_v [3]     = '{default: '0};

  wire  [2:0]  in_ready_v;
  wire  [2:0]  out_valid_v;
  wire  [2:0]  cout_v;
  wire  [2:0]  ovf_v;
  wire  [2:0]  zero_v;
  wire  [7:0]  s0;
  wire  [31:0] s1;
  wire  [7:0]  s2;
  wire  [31:0] s_v [3];

  assign s_v[0] = {24'd0, s0};
  assign s_v[1] = s1;
  assign s_v[2] = {24'd0, s2};

  pipelined_addsub_nbit #(.WIDTH(8), .CHUNK(4)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .a(a_v[0][7:0]), .b(b_v[0][7:0]), .cin(cin_v[0]), .op(op_v[0]),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]), .s(s0),
    .cout(cout_v[0]), .ovf(ovf_v[0]), .zero(zero_v[0])
  );

  pipelined_addsub_nbit #(.WIDTH(32), .CHUNK(8)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .a(a_v[1]), .b(b_v[1]), .cin(cin_v[1]), .op(op_v[1]),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]), .s(s1),
    .cout(cout_v[1]), .ovf(ovf_v[1]), .zero(zero_v[1])
  );

  pipelined_addsub_nbit #(.WIDTH(8), .CHUNK(8)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .a(a_v[2][7:0]), .b(b_v[2][7:0]), .cin(cin_v[2]), .op(op_v[2]),
    .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]), .s(s2),
    .cout(cout_v[2]), .ovf(ovf_v[2]), .zero(zero_v[2])
  );

  task automatic check(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
    total++;
    if (got_v !== exp_v) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got_v, exp_v);
    end
  endtask

  // Packed observation: {ovf, zero, cout, s}
  function automatic logic [34:0] got(input int i);
    return {ovf_v[i], zero_v[i], cout_v[i], s_v[i]};
  endfunction

  function automatic logic [34:0] exp8(input logic [7:0] sv, input logic c, input logic o, input logic z);
    return {o, z, c, 24'd0, sv};
  endfunction

  // Reference: plain integer arithmetic; overflow as "true signed result out of range".
  function automatic logic [34:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic ci, input logic o);
    longint ua, ub, full, lim, sa, sb, sr, c, m, sres;
    m    = (64'sd1 <<< w) - 1;
    lim  = 64'sd1 <<< (w - 1);
    ua   = longint'({32'd0, a}) & m;
    ub   = longint'({32'd0, b}) & m;
    c    = ci ? 64'sd1 : 64'sd0;
    sa   = (ua >= lim) ? ua - 2 * lim : ua;
    sb   = (ub >= lim) ? ub - 2 * lim : ub;
    if (!o) begin
      full = ua + ub + c;
      sr   = sa + sb + c;
    end else begin
      full = ua - ub - c + 2 * lim;
      sr   = sa - sb - c;
    end
    sres = full & m;
    return {(sr >= lim) || (sr < -lim), sres == 0, ((full >>> w) & 1) != 0, sres[31:0]};
  endfunction

  function automatic logic [31:0] pick(input int w, input logic [31:0] mask);
    logic [31:0] msb;
    msb = 32'd1 << (w - 1);
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return mask;
      2:       return msb;
      3:       return msb - 1;
      default: return $urandom & mask;
    endcase
  endfunction

  // One isolated transaction on the 8/4 instance; checks exact 2-cycle latency.
  task automatic txn(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic ci, input logic o, input logic [34:0] e);
    @(posedge clk); #1;
    a_v[0] = {24'd0, a}; b_v[0] = {24'd0, b}; cin_v[0] = ci; op_v[0] = o;
    in_valid_v[0] = 1'b1; out_ready_v[0] = 1'b1;
    @(negedge clk); check({tag, "_rdy"}, in_ready_v[0], 1);
    @(posedge clk); #1; in_valid_v[0] = 1'b0;
    @(negedge clk); check({tag, "_early"}, out_valid_v[0], 0);
    @(negedge clk); check({tag, "_vld"}, out_valid_v[0], 1);
    check(tag, got(0), e);
  endtask

  task automatic sweep(input int i);
    logic [34:0] expq [$];
    int          accq [$];
    bit          latq [$];
    logic [34:0] held, g, e;
    bit          held_v;
    int          done, acc, cyc, w, ac;
    logic [31:0] mask;
    w      = wd[i];
    mask   = (w == 32) ? 32'hFFFF_FFFF : (32'd1 << w) - 1;
    done   = 0; acc = 0; cyc = 0; held_v = 0;
    while (done < 1000 && cyc < 20000) begin
      @(posedge clk); #1; cyc++;
      in_valid_v[i]  = (acc < 1000) && ($urandom_range(0, 4) != 0);
      a_v[i]         = pick(w, mask);
      b_v[i]         = pick(w, mask);
      cin_v[i]       = 1'($urandom_range(0, 1));
      op_v[i]        = 1'($urandom_range(0, 1));
      out_ready_v[i] = (done < 500) || ($urandom_range(0, 3) != 0);
      @(negedge clk);
      g = got(i);
      if (held_v) check($sformatf("hold%0d", i), {out_valid_v[i], g}, {1'b1, held});
      held_v = 0;
      if (out_valid_v[i] && !out_ready_v[i]) begin
        check($sformatf("stall_rdy%0d", i), in_ready_v[i], 0);
        held = g; held_v = 1;
      end else if (out_valid_v[i]) begin
        if (expq.size() == 0) begin
          check($sformatf("spurious%0d", i), out_valid_v[i], 0);
        end else begin
          e  = expq.pop_front();
          ac = accq.pop_front();
          check($sformatf("result%0d_n%0d", i, done), g, e);
          if (latq.pop_front()) check($sformatf("latency%0d", i), cyc - ac, st[i]);
          done++;
        end
      end
      if (in_valid_v[i] && in_ready_v[i]) begin
        expq.push_back(model(w, a_v[i], b_v[i], cin_v[i], op_v[i]));
        accq.push_back(cyc);
        latq.push_back(acc < 490);
        acc++;
      end
    end
    check($sformatf("count%0d", i), done, 1000);
    @(posedge clk); #1; in_valid_v[i] = 1'b0; out_ready_v[i] = 1'b1;
    repeat (4) begin
      @(negedge clk); check($sformatf("idle%0d", i), out_valid_v[i], 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    for (int i = 0; i < 3; i++) check($sformatf("rst_state%0d", i), {out_valid_v[i], got(i)}, 0);
    #9; rst = 1'b0;
    #1; check("rdy_after_rst", in_ready_v, 3'b111);

    txn("add_1e_01", 8'h1E, 8'h01, 1'b0, 1'b0, exp8(8'h1F, 0, 0, 0));
    txn("add_23_04", 8'h23, 8'h04, 1'b0, 1'b0, exp8(8'h27, 0, 0, 0));
    txn("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, exp8(8'h00, 1, 0, 1));
    txn("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, exp8(8'h80, 0, 1, 0));
    txn("add_cin",   8'h0F, 8'h00, 1'b1, 1'b0, exp8(8'h10, 0, 0, 0));
    txn("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1, exp8(8'hFE, 0, 0, 0));
    txn("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, exp8(8'h7F, 1, 1, 0));
    txn("sub_bin",   8'h05, 8'h05, 1'b1, 1'b1, exp8(8'hFF, 0, 0, 0));
    txn("sub_zero",  8'h42, 8'h42, 1'b0, 1'b1, exp8(8'h00, 1, 0, 1));

    // Back-to-back adds (i, i+1): sums 1,3,5,7 on consecutive cycles from cycle 2.
    @(posedge clk); #1;
    for (int j = 0; j < 6; j++) begin
      if (j < 4) begin
        a_v[0] = j; b_v[0] = j + 1; cin_v[0] = 0; op_v[0] = 0; in_valid_v[0] = 1'b1;
      end else begin
        in_valid_v[0] = 1'b0;
      end
      @(negedge clk);
      if (j == 1) check("b2b_early", out_valid_v[0], 0);
      if (j >= 2) check($sformatf("b2b_%0d", j - 2), {out_valid_v[0], got(0)},
                        {1'b1, exp8(8'(2 * (j - 2) + 1), 0, 0, 0)});
      @(posedge clk); #1;
    end

    // Reset with two transactions in flight: outputs clear before any edge.
    out_ready_v[0] = 1'b0;
    a_v[0] = 32'h10; b_v[0] = 32'h01; in_valid_v[0] = 1'b1;
    @(posedge clk); #1; a_v[0] = 32'h20; b_v[0] = 32'h02;
    @(posedge clk); #1; in_valid_v[0] = 1'b0;
    check("mf_pre_vld", out_valid_v[0], 1);
    #1; rst = 1'b1;
    #1; check("mf_rst", {out_valid_v[0], got(0)}, 0);
    @(negedge clk); rst = 1'b0; out_ready_v[0] = 1'b1;
    check("mf_released", out_valid_v[0], 0);
    txn("mf_after", 8'h30, 8'h03, 1'b0, 1'b0, exp8(8'h33, 0, 0, 0));

    for (int i = 0; i < 3; i++) sweep(i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
